// File: rtl/div_seq.sv
// div_seq: sequential 32-bit signed divider (restoring shift/subtract).
// Quotient truncates toward zero; a zero divisor raises data_exception.
// Optional feature macro: DIV_REMAINDER_EN adds the data_remainder output,
// whose sign follows the dividend.
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
`ifdef DIV_REMAINDER_EN
    ,
    output logic [31:0] data_remainder
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  step_cnt;
    logic [64:0] work;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_b;

    logic [31:0] abs_a_in;
    logic [31:0] abs_b_in;
    logic        div_zero;
    logic [33:0] trial;
    logic [31:0] quot_fixed;

    // Operand magnitudes and the per-step trial subtraction.
    // The trial keeps one extra top bit so the sign is unambiguous;
    // the partial remainder never exceeds 32 bits, so bit 64 is zero.
    always_comb begin
        abs_a_in   = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
        abs_b_in   = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
        div_zero   = (data_operandB == 32'd0);
        trial      = work[64:31] - {2'b00, abs_b};
        quot_fixed = (sign_a ^ sign_b) ? (~work[31:0] + 32'd1) : work[31:0];
    end

    // State register; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a start pulse aborts whatever is in flight.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: next_state = IDLE;
            RUN:  next_state = (step_cnt == 5'd31) ? FIX : RUN;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (ctrl_DIV) begin
            next_state = div_zero ? DONE : RUN;
        end
    end

    // Datapath: operand capture, 32 shift/subtract steps and sign correction.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt       <= 5'd0;
            work           <= 65'd0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            abs_b          <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            data_remainder <= 32'd0;
`endif
        end else if (ctrl_DIV) begin
            step_cnt <= 5'd0;
            work     <= {33'd0, abs_a_in};
            sign_a   <= data_operandA[31];
            sign_b   <= data_operandB[31];
            abs_b    <= abs_b_in;
            if (div_zero) begin
                data_result    <= 32'd0;
                data_exception <= 1'b1;
`ifdef DIV_REMAINDER_EN
                data_remainder <= 32'd0;
`endif
            end
        end else if (state == RUN) begin
            step_cnt <= step_cnt + 5'd1;
            if (!trial[33]) begin
                work <= {trial[32:0], work[30:0], 1'b1};
            end else begin
                work <= {work[63:0], 1'b0};
            end
        end else if (state == FIX) begin
            data_result    <= quot_fixed;
            data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            data_remainder <= sign_a ? (~work[63:32] + 32'd1) : work[63:32];
`endif
        end
    end

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == RUN) || (state == FIX);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int checks = 0;
    int errors = 0;

    div_seq dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef DIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    // 10 ns clock; rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a start pulse now and step past its sampling edge (E0);
    // operands are then scrambled to prove they are sampled only at E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clk);
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0BAD_F00D;
    endtask

    // Count cycles after E0 until ready (bounded); lat = -1 on timeout.
    task automatic wait_ready(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (data_resultRDY) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl_DIV = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (data_result !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_result got %h want %h", data_result, 32'd0);
        end
        checks++;
        if (data_exception !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_exc got %b want 0", data_exception);
        end
        checks++;
        if (data_resultRDY !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rdy got %b want 0", data_resultRDY);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy got %b want 0", busy);
        end
    endtask

    task automatic test_signed_div();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vq [3];
        logic [31:0] vr [3];
        int lat, bc;
        va[0] = 32'd100;        vb[0] = 32'd7;          vq[0] = 32'd14;         vr[0] = 32'd2;
        va[1] = 32'hFFFFFF9C;   vb[1] = 32'd7;          vq[1] = 32'hFFFFFFF2;   vr[1] = 32'hFFFFFFFE;
        va[2] = 32'd100;        vb[2] = 32'hFFFFFFF9;   vq[2] = 32'hFFFFFFF2;   vr[2] = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(va[i], vb[i]);
            wait_ready(lat, bc);
            checks++;
            if (lat !== 33) begin
                errors++; $display("[TB] FAIL div%0d_latency got %0d want 33", i, lat);
            end
            checks++;
            if (bc !== 33) begin
                errors++; $display("[TB] FAIL div%0d_busy_cycles got %0d want 33", i, bc);
            end
            checks++;
            if (data_result !== vq[i]) begin
                errors++; $display("[TB] FAIL div%0d_result got %h want %h", i, data_result, vq[i]);
            end
            checks++;
            if (data_exception !== 1'b0) begin
                errors++; $display("[TB] FAIL div%0d_exc got %b want 0", i, data_exception);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("[TB] FAIL div%0d_busy_in_done got %b want 0", i, busy);
            end
`ifdef DIV_REMAINDER_EN
            checks++;
            if (data_remainder !== vr[i]) begin
                errors++; $display("[TB] FAIL div%0d_rem got %h want %h", i, data_remainder, vr[i]);
            end
`endif
            @(negedge clk);
            checks++;
            if (data_resultRDY !== 1'b0) begin
                errors++; $display("[TB] FAIL div%0d_rdy_one_cycle got %b want 0", i, data_resultRDY);
            end
        end
    endtask

    task automatic test_zero_div();
        int lat, bc;
        @(negedge clk);
        issue(32'd5, 32'd0);
        wait_ready(lat, bc);
        checks++;
        if (lat !== 0) begin
            errors++; $display("[TB] FAIL zero_latency got %0d want 0", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_busy got %b want 0", busy);
        end
        checks++;
        if (data_exception !== 1'b1) begin
            errors++; $display("[TB] FAIL zero_exc got %b want 1", data_exception);
        end
        checks++;
        if (data_result !== 32'd0) begin
            errors++; $display("[TB] FAIL zero_result got %h want 0", data_result);
        end
`ifdef DIV_REMAINDER_EN
        checks++;
        if (data_remainder !== 32'd0) begin
            errors++; $display("[TB] FAIL zero_rem got %h want 0", data_remainder);
        end
`endif
        @(negedge clk);
        checks++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_after got rdy=%b busy=%b want 0 0", data_resultRDY, busy);
        end
        checks++;
        if (data_exception !== 1'b1) begin
            errors++; $display("[TB] FAIL zero_exc_hold got %b want 1", data_exception);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [31:0] vq [2];
        int lat, bc;
        va[0] = 32'h80000000; vb[0] = 32'hFFFFFFFF; vq[0] = 32'h80000000;
        va[1] = 32'h7FFFFFFF; vb[1] = 32'd1;        vq[1] = 32'h7FFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            issue(va[i], vb[i]);
            wait_ready(lat, bc);
            checks++;
            if (lat !== 33) begin
                errors++; $display("[TB] FAIL bound%0d_latency got %0d want 33", i, lat);
            end
            checks++;
            if (data_result !== vq[i]) begin
                errors++; $display("[TB] FAIL bound%0d_result got %h want %h", i, data_result, vq[i]);
            end
            checks++;
            if (data_exception !== 1'b0) begin
                errors++; $display("[TB] FAIL bound%0d_exc got %b want 0", i, data_exception);
            end
`ifdef DIV_REMAINDER_EN
            checks++;
            if (data_remainder !== 32'd0) begin
                errors++; $display("[TB] FAIL bound%0d_rem got %h want 0", i, data_remainder);
            end
`endif
        end
    endtask

    task automatic test_abort();
        int lat, bc;
        int early = 0;
        @(negedge clk);
        issue(32'd1000, 32'd3);
        for (int k = 0; k < 9; k++) begin
            if (data_resultRDY) early++;
            @(negedge clk);
        end
        issue(32'd50, 32'd5);
        wait_ready(lat, bc);
        checks++;
        if (early !== 0) begin
            errors++; $display("[TB] FAIL abort_early_rdy got %0d want 0", early);
        end
        checks++;
        if (lat !== 33) begin
            errors++; $display("[TB] FAIL abort_latency got %0d want 33", lat);
        end
        checks++;
        if (data_result !== 32'd10) begin
            errors++; $display("[TB] FAIL abort_result got %h want %h", data_result, 32'd10);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int rdy_seen = 0;
        @(negedge clk);
        issue(32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_outputs got res=%h exc=%b want 0 0", data_result, data_exception);
        end
        checks++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_ctrl got busy=%b rdy=%b want 0 0", busy, data_resultRDY);
        end
        for (int k = 0; k < 40; k++) begin
            if (data_resultRDY || busy) rdy_seen++;
            @(negedge clk);
        end
        checks++;
        if (rdy_seen !== 0) begin
            errors++; $display("[TB] FAIL midreset_activity got %0d want 0", rdy_seen);
        end
        // Start and reset on the same edge: reset wins.
        ctrl_DIV = 1'b1; reset = 1'b1;
        data_operandA = 32'd8; data_operandB = 32'd2;
        @(negedge clk);
        ctrl_DIV = 1'b0; reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_wins got busy=%b rdy=%b want 0 0", busy, data_resultRDY);
        end
        issue(32'd9, 32'd3);
        wait_ready(lat, bc);
        checks++;
        if (lat !== 33 || data_result !== 32'd3) begin
            errors++; $display("[TB] FAIL after_reset_div got lat=%0d res=%h want 33 %h", lat, data_result, 32'd3);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        @(negedge clk);
        issue(32'd20, 32'd4);
        wait_ready(lat, bc);
        checks++;
        if (lat !== 33 || data_result !== 32'd5) begin
            errors++; $display("[TB] FAIL b2b_first got lat=%0d res=%h want 33 %h", lat, data_result, 32'd5);
        end
        // Start while the ready pulse is still visible.
        issue(32'd21, 32'hFFFFFFFD);
        wait_ready(lat, bc);
        checks++;
        if (lat !== 33) begin
            errors++; $display("[TB] FAIL b2b_latency got %0d want 33", lat);
        end
        checks++;
        if (data_result !== 32'hFFFFFFF9) begin
            errors++; $display("[TB] FAIL b2b_result got %h want %h", data_result, 32'hFFFFFFF9);
        end
`ifdef DIV_REMAINDER_EN
        checks++;
        if (data_remainder !== 32'd0) begin
            errors++; $display("[TB] FAIL b2b_rem got %h want 0", data_remainder);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_signed_div();
        test_zero_div();
        test_boundary();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
